// File: rtl/exc_redirect_pkg.sv
// Shared definitions for the exception/ERET redirect path and the PC generator.
package exc_redirect_pkg;

    // Redirect target for exceptions and interrupts, and the boot PC.
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
    localparam logic [31:0] RESET_PC           = 32'hBFC00000;

    // Wide enough for an in-flight count of up to 7.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2
    } state_e;

    // An exception takes priority over an ERET raised in the same cycle.
    function automatic logic [31:0] select_target(input logic        exc,
                                                  input logic [31:0] vec,
                                                  input logic [31:0] epc);
        return exc ? vec : epc;
    endfunction

endpackage

// File: rtl/fetch_outstanding_cnt.sv
// Up/down counter of fetch requests in flight, saturating at 0 and at
// MAX_OUTSTANDING, with a sticky error flag on any over/underflow attempt.
module fetch_outstanding_cnt
    import exc_redirect_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_next_out,
    output logic             o_ovf_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_err;
    logic             w_over;
    logic             w_under;
    logic [CNT_W-1:0] w_next;

    // Next count: simultaneous inc and dec cancel; out-of-range moves saturate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_next  = r_cnt;
        w_over  = i_inc && !i_dec && (r_cnt == MAX_CNT);
        w_under = i_dec && !i_inc && (r_cnt == '0);
        if (i_inc && !i_dec && !w_over) begin
            w_next = r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && !w_under) begin
            w_next = r_cnt - CNT_W'(1);
        end
    end

    // Count register and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_cnt <= w_next;
            if (w_over || w_under) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign o_next_out = w_next;
    assign o_ovf_err  = r_ovf_err;

endmodule

// File: rtl/exc_redirect.sv
// Exception/ERET redirect unit: flushes the pipeline, drains squashed fetch
// responses, then hands one redirect PC to the PC generator.
module exc_redirect
    import exc_redirect_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_oc,
    input  logic        eret,
    input  logic [31:0] cp0_epc,
    input  logic        inst_req,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        flush,
    output logic        hold_req,
    output logic        drop_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        ovf_err
);

    state_e           r_state;
    logic [31:0]      r_target;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_flush;

    logic             w_event;
    logic [31:0]      w_sel_target;
    logic [CNT_W-1:0] w_next_out;

    assign w_event      = exc_oc || eret;
    assign w_sel_target = select_target(exc_oc, EXC_VECTOR, cp0_epc);

    fetch_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_out_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .i_inc      (inst_req && inst_addr_ok),
        .i_dec      (inst_data_ok),
        .o_next_out (w_next_out),
        .o_ovf_err  (ovf_err)
    );

    // Redirect FSM, target latch and count of responses still to be dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_target   <= '0;
            r_drop_cnt <= '0;
            r_flush    <= 1'b0;
        end else begin
            // Every event flushes, including a re-trigger during a redirect.
            r_flush <= w_event;
            case (r_state)
                IDLE: begin
                    if (w_event) begin
                        r_target   <= w_sel_target;
                        // Includes this cycle's accept, excludes this cycle's response.
                        r_drop_cnt <= w_next_out;
                        r_state    <= (w_next_out != '0) ? DRAIN : ISSUE;
                    end
                end
                DRAIN: begin
                    // hold_req blocks new requests, so only the target moves on re-trigger.
                    if (w_event) begin
                        r_target <= w_sel_target;
                    end
                    if (inst_data_ok) begin
                        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                        if (r_drop_cnt == CNT_W'(1)) begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // An event coinciding with acceptance is lost; the PC stays stable.
                    if (redirect_ready) begin
                        r_state <= IDLE;
                    end else if (w_event) begin
                        r_target <= w_sel_target;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign flush          = r_flush;
    assign hold_req       = (r_state != IDLE);
    assign redirect_valid = (r_state == ISSUE);
    assign redirect_pc    = r_target;
    assign drop_data      = inst_data_ok && (r_state == DRAIN);

endmodule

// File: tb/tb_exc_redirect.sv
// Self-checking bench for exc_redirect: directed cases plus randomized
// redirect scenarios checked against a transaction-level model.
module tb_exc_redirect;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_oc, eret, inst_req, inst_addr_ok, inst_data_ok, redirect_ready;
    logic [31:0] cp0_epc;
    logic        flush, hold_req, drop_data, redirect_valid, ovf_err;
    logic [31:0] redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    exc_redirect #(
        .MAX_OUTSTANDING (2),
        .EXC_VECTOR      (32'hBFC00380)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .exc_oc         (exc_oc),
        .eret           (eret),
        .cp0_epc        (cp0_epc),
        .inst_req       (inst_req),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .flush          (flush),
        .hold_req       (hold_req),
        .drop_data      (drop_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; registered outputs are settled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_oc         = 1'b0;
        eret           = 1'b0;
        inst_req       = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        redirect_ready = 1'b0;
    endtask

    // One complete redirect transaction. The model: k requests go out, the
    // event cycle may add one accept and/or retire one response, every
    // response still owed after that is dropped, then the redirect is offered
    // until accepted. The target is the vector if exc_oc was seen, else epc;
    // a later exc_oc during the drain replaces it with the vector.
    task automatic scenario(input int k, input bit ex, input bit er, input logic [31:0] epc,
                            input bit acc, input bit dat, input bit mid, input int delay);
        int          drops;
        int          gaps;
        logic [31:0] tgt;
        for (int i = 0; i < k; i++) begin
            inst_req     = 1'b1;
            inst_addr_ok = 1'b1;
            tick();
        end
        clear_inputs();
        tgt   = ex ? VEC : epc;
        drops = k + int'(acc) - int'(dat);

        // Event cycle: the response here is not dropped.
        exc_oc       = ex;
        eret         = er;
        cp0_epc      = epc;
        inst_req     = acc;
        inst_addr_ok = acc;
        inst_data_ok = dat;
        #1 chk("evt_drop_data", {31'd0, drop_data}, 32'd0);
        tick();
        clear_inputs();
        cp0_epc = $urandom;
        chk("flush", {31'd0, flush}, 32'd1);
        chk("hold_evt", {31'd0, hold_req}, 32'd1);
        chk("valid_evt", {31'd0, redirect_valid}, {31'd0, drops == 0});

        for (int d = 0; d < drops; d++) begin
            if (d == 0 && mid) begin
                exc_oc = 1'b1;
                tick();
                exc_oc = 1'b0;
                tgt    = VEC;
                chk("mid_flush", {31'd0, flush}, 32'd1);
            end
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                chk("drain_valid", {31'd0, redirect_valid}, 32'd0);
                tick();
            end
            inst_data_ok = 1'b1;
            #1 chk("drop_data", {31'd0, drop_data}, 32'd1);
            tick();
            inst_data_ok = 1'b0;
        end

        chk("valid", {31'd0, redirect_valid}, 32'd1);
        chk("redirect_pc", redirect_pc, tgt);
        for (int r = 0; r < delay; r++) begin
            tick();
            chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
            chk("hold_pc", redirect_pc, tgt);
            chk("hold_req_issue", {31'd0, hold_req}, 32'd1);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("idle_valid", {31'd0, redirect_valid}, 32'd0);
        chk("idle_hold", {31'd0, hold_req}, 32'd0);
        chk("idle_flush", {31'd0, flush}, 32'd0);
        chk("no_ovf", {31'd0, ovf_err}, 32'd0);
    endtask

    initial begin
        int  k, sel;
        bit  acc, dat, mid;

        clear_inputs();
        cp0_epc = '0;
        resetn  = 1'b0;
        #12;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_hold", {31'd0, hold_req}, 32'd0);
        chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
        chk("rst_drop", {31'd0, drop_data}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Directed cases.
        scenario(0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0);
        scenario(2, 1'b0, 1'b1, 32'h80001234, 1'b0, 1'b0, 1'b0, 1);
        scenario(0, 1'b1, 1'b1, 32'h80000010, 1'b0, 1'b0, 1'b0, 0);
        scenario(1, 1'b0, 1'b1, 32'h80004000, 1'b1, 1'b0, 1'b0, 0);
        scenario(0, 1'b0, 1'b1, 32'h80002000, 1'b0, 1'b0, 1'b0, 4);
        scenario(2, 1'b0, 1'b1, 32'h80003000, 1'b0, 1'b1, 1'b0, 0);
        scenario(2, 1'b0, 1'b1, 32'h80005000, 1'b0, 1'b0, 1'b1, 2);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            k   = $urandom_range(0, 2);
            acc = (k < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            dat = (k > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            mid = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            scenario(k, sel != 1, sel != 0, $urandom, acc, dat, mid, $urandom_range(0, 3));
        end

        // Overflow: three accepts with nothing returned at MAX_OUTSTANDING=2.
        for (int i = 0; i < 3; i++) begin
            inst_req     = 1'b1;
            inst_addr_ok = 1'b1;
            tick();
            if (i == 1) chk("ovf_at_max", {31'd0, ovf_err}, 32'd0);
        end
        clear_inputs();
        chk("ovf_set", {31'd0, ovf_err}, 32'd1);
        tick();
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);

        // Enter DRAIN, then reset asynchronously in the middle of it.
        eret    = 1'b1;
        cp0_epc = 32'h80006000;
        tick();
        eret = 1'b0;
        chk("ovf_drain_hold", {31'd0, hold_req}, 32'd1);
        chk("ovf_drain_valid", {31'd0, redirect_valid}, 32'd0);
        tick();
        #2 resetn = 1'b0;
        inst_data_ok = 1'b1;
        #1;
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_hold", {31'd0, hold_req}, 32'd0);
        chk("arst_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst_pc", redirect_pc, 32'd0);
        chk("arst_ovf", {31'd0, ovf_err}, 32'd0);
        chk("arst_drop", {31'd0, drop_data}, 32'd0);
        inst_data_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        scenario(1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
